// File: rtl/aes_round_engine.sv
// ---------------------------------------------------------------------------
// aes_round_engine
//   Iterative AES-128 encryption datapath. One round is processed per pass
//   through K_REQ -> K_CAP -> S_REQ. Round keys come from an external
//   key-expansion store and SubBytes is done by an external S-box unit.
//   ShiftRows, MixColumns and AddRoundKey are done locally.
//
// Ports
//   clk        in   single clock, all state updates on posedge
//   rst        in   asynchronous, active-high reset
//   start      in   request to encrypt pt_in (only looked at in IDLE)
//   pt_in      in   128-bit plaintext, byte0 = [127:120], column-major
//   key_done   in   round keys 0..NR are valid in the key store
//   key_rd_en  out  one-cycle round-key read strobe
//   key_addr   out  round-key index 0..NR
//   rk_in      in   round key, valid the cycle after key_rd_en
//   sb_rd_en   out  S-box request, held until sb_done
//   sb_in      out  state bytes to substitute
//   sb_out     in   substituted bytes, same byte order as sb_in
//   sb_done    in   sb_out valid this cycle
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse, ct_out valid
//   ct_out     out  ciphertext, held until the next done or reset
// ---------------------------------------------------------------------------
module aes_round_engine #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] pt_in,
  input  logic         key_done,
  output logic         key_rd_en,
  output logic [3:0]   key_addr,
  input  logic [127:0] rk_in,
  output logic         sb_rd_en,
  output logic [127:0] sb_in,
  input  logic [127:0] sb_out,
  input  logic         sb_done,
  output logic         busy,
  output logic         done,
  output logic [127:0] ct_out
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] K_REQ = 3'd1;
  localparam logic [2:0] K_CAP = 3'd2;
  localparam logic [2:0] S_REQ = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  logic [2:0]   fsm_q,   fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q,    ct_d;
  logic         done_q,  done_d;

  // Multiply a GF(2^8) element by x, reducing with 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (row r, column c) lives at index 4*c + r, counted from the MSB.
  // Row r is rotated left by r byte positions.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  // Each column is multiplied by the circulant matrix {02 03 01 01}.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    logic [7:0]   b0, b1, b2, b3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      b0 = xtime(a0);
      b1 = xtime(a1);
      b2 = xtime(a2);
      b3 = xtime(a3);
      res[127-32*c -: 8] = b0 ^ (b1 ^ a1) ^ a2 ^ a3;
      res[119-32*c -: 8] = a0 ^ b1 ^ (b2 ^ a2) ^ a3;
      res[111-32*c -: 8] = a0 ^ a1 ^ b2 ^ (b3 ^ a3);
      res[103-32*c -: 8] = (b0 ^ a0) ^ a1 ^ a2 ^ b3;
    end
    return res;
  endfunction

  // Next-state logic. Round 0 is a bare AddRoundKey; rounds 1..NR-1 apply
  // MixColumns before the key; the last round skips MixColumns. SubBytes and
  // ShiftRows are applied when the S-box answers, so K_CAP always sees a
  // state that has already been through SubBytes/ShiftRows for that round.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start && key_done) begin
          state_d = pt_in;
          round_d = 4'd0;
          fsm_d   = K_REQ;
        end
      end
      K_REQ: begin
        fsm_d = K_CAP;
      end
      K_CAP: begin
        if (round_q == 4'd0) begin
          state_d = state_q ^ rk_in;
          round_d = 4'd1;
          fsm_d   = S_REQ;
        end else if (round_q == LAST_ROUND) begin
          state_d = state_q ^ rk_in;
          fsm_d   = DONE;
        end else begin
          state_d = mix_columns(state_q) ^ rk_in;
          round_d = round_q + 4'd1;
          fsm_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (sb_done) begin
          state_d = shift_rows(sb_out);
          fsm_d   = K_REQ;
        end
      end
      DONE: begin
        ct_d   = state_q;
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State registers; reset clears everything so outputs are zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  // Strobes are decoded from the state, so they can never overlap and drop
  // in the cycle right after the state is left.
  assign key_rd_en = (fsm_q == K_REQ);
  assign key_addr  = key_rd_en ? round_q : 4'd0;
  assign sb_rd_en  = (fsm_q == S_REQ);
  assign sb_in     = sb_rd_en ? state_q : '0;
  assign busy      = (fsm_q != IDLE);
  assign done      = done_q;
  assign ct_out    = ct_q;

endmodule
